// File: rtl/aes_pkg.sv
// Shared AES definitions for the core sequencer and its helpers.
//  - AES_BLOCK_W / AES_WORD_W : datapath widths
//  - seq_state_e              : sequencer FSM states
//  - FIPS_KEY/FIPS_PT/FIPS_CT : FIPS-197 Appendix C.1 AES-128 test vector
package aes_pkg;

   localparam int unsigned AES_BLOCK_W = 128;
   localparam int unsigned AES_WORD_W  = 32;

   typedef enum logic [2:0] {
      StIdle,
      StKeyStart,
      StKeyWait,
      StEncStart,
      StEncWait,
      StDone
   } seq_state_e;

   localparam logic [AES_BLOCK_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [AES_BLOCK_W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [AES_BLOCK_W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_sbox_mux.sv
// Shared S-box operand select and result fan-out.
// Ports:
//  use_ks_i         in  1   1 = key-expansion unit owns the S-box
//  ks_before_sub_i  in  32  operand from key-expansion unit
//  enc_before_sub_i in  32  operand from encryption block
//  sbox_out_i       in  32  combinational S-box result
//  sbox_in_o        out 32  operand to the S-box
//  sub_result_o     out 32  S-box result fanned out to both users
module aes_sbox_mux
   import aes_pkg::*;
(
   input  logic                  use_ks_i,
   input  logic [AES_WORD_W-1:0] ks_before_sub_i,
   input  logic [AES_WORD_W-1:0] enc_before_sub_i,
   input  logic [AES_WORD_W-1:0] sbox_out_i,
   output logic [AES_WORD_W-1:0] sbox_in_o,
   output logic [AES_WORD_W-1:0] sub_result_o
);

   always_comb begin
      sbox_in_o    = use_ks_i ? ks_before_sub_i : enc_before_sub_i;
      // Both users see every result; each only consumes it while it owns the S-box.
      sub_result_o = sbox_out_i;
   end

endmodule

// File: rtl/aes_core_sequencer.sv
// Top-level sequencer for the AES-128 datapath.
// Accepts key-load / encrypt commands, pulses the key-expansion unit or the
// encryption block, shares one 32-bit S-box between them, latches ciphertext
// and flags timeouts or encrypt-without-key as a sticky error.
// Ports:
//  clk, reset (async, active-low)
//  cmd_valid/cmd_key/cmd_ready    : command handshake (cmd_key 1 = key expansion)
//  key_init/key_ready             : key-expansion start pulse / idle-done
//  enc_next/enc_ready             : encryption start pulse / idle-done
//  enc_new_block                  : ciphertext from the encryption block
//  ks_before_sub/enc_before_sub   : S-box operands from the two users
//  sbox_in/sbox_out/sub_result    : shared S-box interface
//  result/result_valid            : last ciphertext and its update pulse
//  key_valid, error               : expanded key present, sticky error
module aes_core_sequencer
   import aes_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7   // must hold TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   input  logic                   cmd_key,
   output logic                   cmd_ready,
   output logic                   key_init,
   input  logic                   key_ready,
   output logic                   enc_next,
   input  logic                   enc_ready,
   input  logic [AES_BLOCK_W-1:0] enc_new_block,
   input  logic [AES_WORD_W-1:0]  ks_before_sub,
   input  logic [AES_WORD_W-1:0]  enc_before_sub,
   output logic [AES_WORD_W-1:0]  sbox_in,
   input  logic [AES_WORD_W-1:0]  sbox_out,
   output logic [AES_WORD_W-1:0]  sub_result,
   output logic [AES_BLOCK_W-1:0] result,
   output logic                   result_valid,
   output logic                   key_valid,
   output logic                   error
);

   localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_e             state_q, state_d;
   logic [AES_BLOCK_W-1:0] result_q, result_d;
   logic                   key_valid_q, key_valid_d;
   logic                   error_q, error_d;
   logic [CNT_W-1:0]       wd_q, wd_d;
   logic [CNT_W-1:0]       wd_inc;
   logic                   wd_expired;
   logic                   use_ks;

   // Saturating increment; the FSM leaves the wait state long before saturation.
   assign wd_inc     = (wd_q == {CNT_W{1'b1}}) ? wd_q : wd_q + 1'b1;
   assign wd_expired = (wd_q == WdLast);

   always_comb begin
      state_d      = state_q;
      result_d     = result_q;
      key_valid_d  = key_valid_q;
      error_d      = error_q;
      wd_d         = wd_q;
      cmd_ready    = 1'b0;
      key_init     = 1'b0;
      enc_next     = 1'b0;
      result_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               error_d = 1'b0;
               if (cmd_key) begin
                  key_valid_d = 1'b0;
                  state_d     = StKeyStart;
               end else if (key_valid_q) begin
                  state_d = StEncStart;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         StKeyStart: begin
            // key_ready is stale here: the unit only sees key_init on the next edge.
            key_init = 1'b1;
            wd_d     = '0;
            state_d  = StKeyWait;
         end
         StKeyWait: begin
            // Completion is checked first so a ready on the timeout cycle wins.
            if (key_ready) begin
               key_valid_d = 1'b1;
               state_d     = StIdle;
            end else if (wd_expired) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else begin
               wd_d = wd_inc;
            end
         end
         StEncStart: begin
            enc_next = 1'b1;
            wd_d     = '0;
            state_d  = StEncWait;
         end
         StEncWait: begin
            if (enc_ready) begin
               result_d = enc_new_block;
               state_d  = StDone;
            end else if (wd_expired) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else begin
               wd_d = wd_inc;
            end
         end
         StDone: begin
            result_valid = 1'b1;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
      end else if (state_q == StEncWait) begin
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= key_valid_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   // S-box ownership follows the registered state, so the switch costs no cycle.
   assign use_ks = (state_q == StKeyStart) || (state_q == StKeyWait);

   aes_sbox_mux u_sbox_mux (
      .use_ks_i         (use_ks),
      .ks_before_sub_i  (ks_before_sub),
      .enc_before_sub_i (enc_before_sub),
      .sbox_out_i       (sbox_out),
      .sbox_in_o        (sbox_in),
      .sub_result_o     (sub_result)
   );

   assign result    = result_q;
   assign key_valid = key_valid_q;
   assign error     = error_q;

endmodule
